// File: rtl/poly_mult_host_seq.sv
// Host-side sequencer for the poly_mult accelerator: streams WEIGHT positions and
// N_WORDS random words into the load/key/data port, fires the multiply, returns the result.
module poly_mult_host_seq #(
   parameter int WEIGHT  = 66,
   parameter int N_WORDS = 553,
   parameter int KEY_W   = 10,
   parameter int DATA_W  = 128,
   parameter int TIMEOUT = 1048575
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go_i,
   input  logic              pos_valid_i,
   input  logic [15:0]       pos_data_i,
   output logic              pos_ready_o,
   input  logic              rnd_valid_i,
   input  logic [31:0]       rnd_data_i,
   output logic              rnd_ready_o,
   output logic              load_o,
   output logic [KEY_W-1:0]  key_o,
   output logic [DATA_W-1:0] data_o,
   input  logic              busy_i,
   input  logic [DATA_W-1:0] res_i,
   output logic              res_valid_o,
   output logic [DATA_W-1:0] res_data_o,
   output logic              done_o,
   output logic              error_o
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_LPOS, S_GAPP, S_WPOS, S_LRND, S_GAPR,
      S_WRND, S_FIRE, S_GAPF, S_WRUN, S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [KEY_W-1:0]   idx;
   logic [TMR_W-1:0]   timer;
   logic               start, last_pos, last_rnd, timer_exp;
   logic               cmd_ld;
   logic [KEY_W-1:0]   cmd_key;
   logic [DATA_W-1:0]  cmd_data;

   // Bit DATA_W-1 keeps a write distinct from the all-zero read and all-ones fire opcodes.
   function automatic logic [DATA_W-1:0] wr_word(input logic [31:0] payload);
      logic [DATA_W-1:0] w;
      w             = '0;
      w[DATA_W-1]   = 1'b1;
      w[31:0]       = payload;
      return w;
   endfunction

   assign start     = go_i && ((state == S_IDLE) || (state == S_DONE));
   assign last_pos  = (idx == KEY_W'(WEIGHT - 1));
   assign last_rnd  = (idx == KEY_W'(N_WORDS - 1));
   assign timer_exp = (timer == TMR_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0;
         timer       <= '0;
         load_o      <= 1'b0;
         key_o       <= '0;
         data_o      <= '0;
         res_valid_o <= 1'b0;
         res_data_o  <= '0;
         error_o     <= 1'b0;
      end else begin
         state       <= state_nxt;
         load_o      <= cmd_ld;
         res_valid_o <= 1'b0;
         if (cmd_ld) begin
            key_o  <= cmd_key;
            data_o <= cmd_data;
         end
         if (start)
            idx <= '0;
         else if (state == S_WPOS && !busy_i)
            idx <= last_pos ? '0 : idx + 1'b1;
         else if (state == S_WRND && !busy_i)
            idx <= last_rnd ? '0 : idx + 1'b1;
         if (state == S_FIRE)
            timer <= '0;
         else if (state == S_WRUN)
            timer <= timer + 1'b1;
         // A completed run wins over a timeout landing on the same cycle.
         if (state == S_WRUN && !busy_i) begin
            res_data_o  <= res_i;
            res_valid_o <= 1'b1;
         end
         if (start)
            error_o <= 1'b0;
         else if (state == S_WRUN && busy_i && timer_exp)
            error_o <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (go_i) state_nxt = S_LPOS;
         S_LPOS:         if (pos_valid_i) state_nxt = S_GAPP;
         S_GAPP:         state_nxt = S_WPOS;
         S_WPOS:         if (!busy_i) state_nxt = last_pos ? S_LRND : S_LPOS;
         S_LRND:         if (rnd_valid_i) state_nxt = S_GAPR;
         S_GAPR:         state_nxt = S_WRND;
         S_WRND:         if (!busy_i) state_nxt = last_rnd ? S_FIRE : S_LRND;
         S_FIRE:         state_nxt = S_GAPF;
         S_GAPF:         state_nxt = S_WRUN;
         S_WRUN:         if (!busy_i || timer_exp) state_nxt = S_DONE;
         default:        state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pos_ready_o = (state == S_LPOS);
      rnd_ready_o = (state == S_LRND);
      done_o      = (state == S_DONE);
      cmd_ld      = 1'b0;
      cmd_key     = '0;
      cmd_data    = '0;
      case (state)
         S_LPOS: if (pos_valid_i) begin
            cmd_ld   = 1'b1;
            cmd_key  = idx;
            cmd_data = wr_word({16'b0, pos_data_i});
         end
         S_LRND: if (rnd_valid_i) begin
            cmd_ld   = 1'b1;
            cmd_key  = idx + KEY_W'(WEIGHT);
            cmd_data = wr_word(rnd_data_i);
         end
         S_FIRE: begin
            cmd_ld   = 1'b1;
            cmd_key  = KEY_W'(1);
            cmd_data = '1;
         end
         default: ;
      endcase
   end

endmodule
